alu_req_driver: RTL and testbench

Initiator-side counterpart to the ALU port set. It accepts operation requests on a valid/ready stream and drives `a`/`b`/`op` into the ALU. It tracks each issued operation through the ALU's fixed latency, captures `result` at the correct cycle, and returns it with its opcode on a valid/ready response stream through a small FIFO. It replaces the bench-side driving of the ALU ports, so any synthesizable master (CPU stub, DMA, test sequencer) can use the ALU with back-pressure.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_req_driver_if.sv | 33 +++
 rtl/alu_rsp_fifo.sv | 57 +++++
 rtl/alu_req_driver.sv | 98 +++++++++
 tb/tb_alu_req_driver.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU request driver: opcodes, data width, response
// payload and the per-stage tag carried alongside an operation in flight.
package alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_t;

    typedef struct packed {
        op_t               op;
        logic [DATA_W-1:0] result;
    } alu_rsp_t;

    // One slot of the latency-tracking pipe: the ALU has no valid of its own.
    typedef struct packed {
        logic vld;
        op_t  op;
    } tag_t;

endpackage

// File: rtl/alu_req_driver_if.sv
// Request stream, ALU operand/result port and response stream bundled together.
// slave: the driver block. master: whoever feeds requests, models the ALU and
// consumes responses.
interface alu_req_driver_if;
    import alu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    op_t               req_op;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    op_t               alu_op;
    logic [DATA_W-1:0] alu_result;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    op_t               rsp_op;

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_op
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_op
    );

endinterface

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO. Pointers wrap naturally (DEPTH is a power of two);
// the count is kept explicitly so the top can do credit accounting with it.
module alu_rsp_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  alu_rsp_t                     i_push_data,
    input  logic                         i_pop,
    output alu_rsp_t                     o_head,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    alu_rsp_t          r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_empty = (r_count == '0);
    assign w_push  = i_push & (r_count != FULL_CNT);
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage needs no reset: it is only read while the count says non-empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    // Pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_req_driver.sv
// Drives a fixed-latency ALU from a valid/ready request stream and returns
// results in issue order on a valid/ready response stream. Requests are only
// accepted while a FIFO slot is guaranteed for them, so captures never stall.
module alu_req_driver
    import alu_pkg::*;
#(
    parameter int ALU_LATENCY = 1,
    parameter int RSP_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_req_driver_if.slave  bus
);

    localparam int CNT_W = $clog2(RSP_DEPTH+1);
    localparam logic [CNT_W:0] CREDIT_LIM = (CNT_W+1)'(RSP_DEPTH);

    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    op_t               r_alu_op;
    tag_t              r_tag [ALU_LATENCY+1];
    logic [CNT_W-1:0]  r_inflight;

    logic              w_issue;
    logic              w_capture;
    logic              w_pop;
    logic              w_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [CNT_W:0]    w_used;
    alu_rsp_t          w_push_data;
    alu_rsp_t          w_head;

    // Credits: everything issued and not yet popped must fit in the FIFO.
    assign w_used        = {1'b0, r_inflight} + {1'b0, w_fifo_count};
    assign bus.req_ready = (w_used < CREDIT_LIM);
    assign w_issue       = bus.req_valid & bus.req_ready;
    assign w_capture     = r_tag[ALU_LATENCY].vld;
    assign w_pop         = bus.rsp_ready & ~w_empty;

    assign bus.alu_a  = r_alu_a;
    assign bus.alu_b  = r_alu_b;
    assign bus.alu_op = r_alu_op;

    assign w_push_data = '{op: r_tag[ALU_LATENCY].op, result: bus.alu_result};

    // Empty FIFO presents zeros rather than stale storage.
    assign bus.rsp_valid  = ~w_empty;
    assign bus.rsp_result = w_empty ? '0 : w_head.result;
    assign bus.rsp_op     = w_empty ? OP_ADD : w_head.op;

    // Operand registers load only on accept and otherwise hold for the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= OP_ADD;
        end else if (w_issue) begin
            r_alu_a  <= bus.req_a;
            r_alu_b  <= bus.req_b;
            r_alu_op <= bus.req_op;
        end
    end

    // Tag pipe: last stage valid means alu_result belongs to that op this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= ALU_LATENCY; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= '{vld: w_issue, op: bus.req_op};
            for (int i = 1; i <= ALU_LATENCY; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    // Operations issued but not yet captured into the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, w_capture})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    alu_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_capture),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_count     (w_fifo_count)
    );

endmodule

// File: tb/tb_alu_req_driver.sv
// Bench for alu_req_driver: main instance at latency 1 against a scoreboard of
// expected results and due cycles, plus latency-0 and latency-3 instances.
module tb_alu_req_driver;
    import alu_pkg::*;

    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_req_driver_if bus  ();
    alu_req_driver_if bus0 ();
    alu_req_driver_if bus3 ();

    alu_req_driver #(.ALU_LATENCY(LAT), .RSP_DEPTH(DEPTH)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_req_driver #(.ALU_LATENCY(0),   .RSP_DEPTH(DEPTH)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    alu_req_driver #(.ALU_LATENCY(3),   .RSP_DEPTH(DEPTH)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    function automatic logic [31:0] alu_f(input op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            default: return a | b;
        endcase
    endfunction

    // ALU models with 1, 0 and 3 edges of latency
    logic [31:0] alu1_q;
    logic [31:0] alu3_q [3];
    always @(posedge clk) begin
        alu1_q    <= alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
        alu3_q[0] <= alu_f(bus3.alu_op, bus3.alu_a, bus3.alu_b);
        alu3_q[1] <= alu3_q[0];
        alu3_q[2] <= alu3_q[1];
    end
    assign bus.alu_result  = alu1_q;
    assign bus0.alu_result = alu_f(bus0.alu_op, bus0.alu_a, bus0.alu_b);
    assign bus3.alu_result = alu3_q[2];

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: each accepted op is due LAT+2 negedges later; outstanding ops
    // (accepted, not popped) never exceed DEPTH and gate req_ready.
    typedef struct {
        logic [31:0] res;
        op_t         op;
        int          due;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] got_q [$];
    int          got_cyc [$];
    int          cyc = 0;
    int          acc_cnt = 0;
    bit          mon_en = 1'b0;
    int          rsp_mode = 1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            chk("req_ready", 32'(bus.req_ready), 32'(sb.size() < DEPTH));
            chk("occupancy", 32'(sb.size() <= DEPTH), 32'd1);
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(sb.size() > 0 && sb[0].due <= cyc));
            if (bus.rsp_valid && sb.size() > 0) begin
                chk("rsp_result", bus.rsp_result, sb[0].res);
                chk("rsp_op", 32'(bus.rsp_op), 32'(sb[0].op));
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                got_q.push_back(bus.rsp_result);
                got_cyc.push_back(cyc);
                if (sb.size() > 0) void'(sb.pop_front());
            end
            if (bus.req_valid && bus.req_ready) begin
                sb.push_back('{alu_f(bus.req_op, bus.req_a, bus.req_b), bus.req_op, cyc + LAT + 2});
                acc_cnt <= acc_cnt + 1;
            end
        end
    end

    // Response back-pressure: 0 = stall, 1 = always ready, 2 = random
    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rsp_mode)
                0:       bus.rsp_ready = 1'b0;
                1:       bus.rsp_ready = 1'b1;
                default: bus.rsp_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    task automatic send(input op_t op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.req_ready) break;
        end
        chk("send_accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300 && sb.size() != 0; n++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int lat;
        bus.req_valid  = 1'b0; bus.req_a  = '0; bus.req_b  = '0; bus.req_op  = OP_ADD;
        bus0.req_valid = 1'b0; bus0.req_a = '0; bus0.req_b = '0; bus0.req_op = OP_ADD;
        bus3.req_valid = 1'b0; bus3.req_a = '0; bus3.req_b = '0; bus3.req_op = OP_ADD;
        bus0.rsp_ready = 1'b1;
        bus3.rsp_ready = 1'b1;

        // reset state
        #12;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_result", bus.rsp_result, 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'(OP_ADD));
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // single ADD: response two edges after the accept
        send(OP_ADD, 32'd5, 32'd7);
        @(posedge clk); #1;
        chk("single_early", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("single_valid", 32'(bus.rsp_valid), 32'd1);
        chk("single_result", bus.rsp_result, 32'd12);
        chk("single_op", 32'(bus.rsp_op), 32'(OP_ADD));
        chk("hold_alu_a", bus.alu_a, 32'd5);
        chk("hold_alu_b", bus.alu_b, 32'd7);
        wait_idle();

        // back-to-back, responses on consecutive cycles
        got_q.delete(); got_cyc.delete();
        send(OP_SUB, 32'd10, 32'd3);
        send(OP_AND, 32'h0000F0F0, 32'h00000FF0);
        send(OP_OR,  32'h1, 32'h8);
        wait_idle();
        chk("b2b_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("b2b_0", got_q[0], 32'd7);
            chk("b2b_1", got_q[1], 32'h000000F0);
            chk("b2b_2", got_q[2], 32'h9);
            chk("b2b_gap1", got_cyc[1] - got_cyc[0], 1);
            chk("b2b_gap2", got_cyc[2] - got_cyc[1], 1);
        end

        // back-pressure: four credits, then stall
        rsp_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        got_q.delete();
        base = acc_cnt;
        for (int i = 1; i <= 4; i++) send(OP_ADD, 32'(i), 32'(i));
        bus.req_valid = 1'b1; bus.req_op = OP_ADD; bus.req_a = 32'd5; bus.req_b = 32'd5;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
        chk("bp_accepted", acc_cnt - base, 4);
        rsp_mode = 1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.req_ready) break;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        send(OP_ADD, 32'd6, 32'd6);
        wait_idle();
        chk("bp_count", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) chk("bp_value", got_q[i], 32'(2 * (i + 1)));

        // random ops at full rate with random response stalls
        got_q.delete();
        rsp_mode = 2;
        for (int i = 0; i < 100; i++)
            send(op_t'($urandom_range(0, 3)), $urandom, $urandom);
        rsp_mode = 1;
        wait_idle();
        chk("rand_count", got_q.size(), 100);

        // asynchronous reset with three ops outstanding
        rsp_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        send(OP_ADD, 32'd100, 32'd1);
        send(OP_SUB, 32'd50, 32'd2);
        send(OP_OR,  32'h30, 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_rsp_result", bus.rsp_result, 32'd0);
        chk("mid_rst_rsp_op", 32'(bus.rsp_op), 32'd0);
        chk("mid_rst_alu_a", bus.alu_a, 32'd0);
        chk("mid_rst_alu_b", bus.alu_b, 32'd0);
        chk("mid_rst_alu_op", 32'(bus.alu_op), 32'(OP_ADD));
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_mode = 1;
        got_q.delete();
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_silent", got_q.size(), 0);
        send(OP_ADD, 32'd1, 32'd1);
        wait_idle();
        chk("post_rst_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("post_rst_result", got_q[0], 32'd2);

        // latency 0 build: response one edge after accept
        bus0.req_valid = 1'b1; bus0.req_op = OP_SUB; bus0.req_a = 32'd20; bus0.req_b = 32'd5;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            lat++;
            if (bus0.rsp_valid) break;
        end
        chk("lat0_cycles", lat, 1);
        chk("lat0_result", bus0.rsp_result, 32'd15);
        chk("lat0_op", 32'(bus0.rsp_op), 32'(OP_SUB));

        // latency 3 build: response four edges after accept
        bus3.req_valid = 1'b1; bus3.req_op = OP_OR; bus3.req_a = 32'hA0; bus3.req_b = 32'h05;
        @(posedge clk); #1;
        bus3.req_valid = 1'b0;
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            lat++;
            if (bus3.rsp_valid) break;
        end
        chk("lat3_cycles", lat, 4);
        chk("lat3_result", bus3.rsp_result, 32'hA5);
        chk("lat3_op", 32'(bus3.rsp_op), 32'(OP_OR));

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
